// File: rtl/dmem_lane_ctrl.sv
// dmem_lane_ctrl: load/store controller over four byte-lane BRAMs with one-cycle registered reads.
// Define DMEM_MISALIGN_EN to allow misaligned half/word accesses split across two rows.
module dmem_lane_ctrl #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      REQ_VALID,
  output logic                      REQ_READY,
  input  logic                      REQ_WE,
  input  logic [ADDR_WIDTH-1:0]     REQ_ADDR,
  input  logic [1:0]                REQ_SIZE,
  input  logic                      REQ_UNSIGNED,
  input  logic [31:0]               REQ_WDATA,
  output logic                      RSP_VALID,
  output logic [31:0]               RSP_RDATA,
  output logic                      RSP_ERR,
  output logic [4*(ADDR_WIDTH-2)-1:0] LANE_W_ADDR,
  output logic [4*(ADDR_WIDTH-2)-1:0] LANE_R_ADDR,
  output logic [3:0]                LANE_WE,
  output logic [3:0]                LANE_RE,
  output logic [31:0]               LANE_DIN,
  input  logic [31:0]               LANE_DOUT
);
  localparam int RW = ADDR_WIDTH - 2;
  typedef enum logic [1:0] {IDLE, ACCESS, COLLECT, RESP} state_t;
  state_t r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [1:0]  r_size;
  logic        r_we, r_uns, r_err;
  logic [31:0] r_wdata, r_rdata;
  logic [2:0]  w_req_n, w_n;
  logic        w_top, w_cross, w_mis, w_err, w_acc;
  logic [3:0]  w_act;
  logic [31:0] w_rb, w_ld;
  logic [RW-1:0] w_row [4];
  assign w_req_n = REQ_SIZE == 2'd0 ? 3'd1 : REQ_SIZE == 2'd1 ? 3'd2 : 3'd4;
  assign w_n     = r_size == 2'd0 ? 3'd1 : r_size == 2'd1 ? 3'd2 : 3'd4;
  assign w_top   = &REQ_ADDR[ADDR_WIDTH-1:2];
  assign w_cross = ({1'b0, REQ_ADDR[1:0]} + w_req_n) > 3'd4;
`ifdef DMEM_MISALIGN_EN
  assign w_mis = 1'b0;
`else
  assign w_mis = (REQ_SIZE == 2'd1 && REQ_ADDR[0]) || (REQ_SIZE == 2'd2 && REQ_ADDR[1:0] != 2'd0);
`endif
  assign w_err     = REQ_SIZE == 2'd3 || (w_top && w_cross) || w_mis;
  assign w_acc     = r_state == ACCESS && !RST;
  assign REQ_READY = r_state == IDLE;
  assign RSP_VALID = r_state == RESP;
  assign RSP_ERR   = r_state == RESP && r_err;
  assign RSP_RDATA = r_rdata;
  // Lane i carries request byte (i - o) mod 4; lanes below the offset wrap to the next row.
  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic [1:0] w_k, w_l;
    logic       w_wr, w_rd;
    assign w_k      = 2'(i) - r_addr[1:0];
    assign w_l      = 2'(i) + r_addr[1:0];
    assign w_act[i] = {1'b0, w_k} < w_n;
    assign w_row[i] = r_addr[ADDR_WIDTH-1:2] + RW'(2'(i) < r_addr[1:0]);
    assign w_wr     = w_acc && r_we && w_act[i];
    assign w_rd     = w_acc && !r_we && w_act[i];
    assign LANE_WE[i] = w_wr;
    assign LANE_RE[i] = w_rd;
    assign LANE_W_ADDR[i*RW +: RW] = w_wr ? w_row[i] : '0;
    assign LANE_R_ADDR[i*RW +: RW] = w_rd ? w_row[i] : '0;
    assign LANE_DIN[8*i +: 8] = w_wr ? r_wdata[{w_k, 3'b000} +: 8] : 8'h00;
    assign w_rb[8*i +: 8] = LANE_DOUT[{w_l, 3'b000} +: 8];
  end
  assign w_ld = r_size == 2'd0 ? {{24{~r_uns & w_rb[7]}}, w_rb[7:0]} :
                r_size == 2'd1 ? {{16{~r_uns & w_rb[15]}}, w_rb[15:0]} : w_rb;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = REQ_VALID ? (w_err ? RESP : ACCESS) : IDLE;
      ACCESS:  w_next = r_we ? RESP : COLLECT;
      COLLECT: w_next = RESP;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_size  <= '0;
      r_we    <= 1'b0;
      r_uns   <= 1'b0;
      r_err   <= 1'b0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && REQ_VALID) begin
        r_addr  <= REQ_ADDR;
        r_size  <= REQ_SIZE;
        r_we    <= REQ_WE;
        r_uns   <= REQ_UNSIGNED;
        r_wdata <= REQ_WDATA;
        r_err   <= w_err;
        if (w_err) r_rdata <= '0;
      end
      if (r_state == ACCESS && r_we) r_rdata <= '0;
      if (r_state == COLLECT) r_rdata <= w_ld;
    end
  end
endmodule

// File: doc/dmem_lane_ctrl.md
Name: dmem_lane_ctrl

Overview:
- Data-memory access controller between the pipelined core's load/store stage and four 8-bit byte-lane BRAMs (lanes 0..3).
- Accepts one byte, half or word request at a time.
- Maps each request byte onto a lane and row, drives the lane write and read ports, and reassembles read bytes into a sign- or zero-extended 32-bit result.
- Sized for lanes with a one-cycle registered read.

Parameters:
- ADDR_WIDTH, 8, byte-address width; each lane holds 2**(ADDR_WIDTH-2) rows and has a row address of ADDR_WIDTH-2 bits.

Ports:
- CLK  in  1  clock; all logic on posedge.
- RST  in  1  synchronous, active-high reset.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  controller can accept a request.
- REQ_WE  in  1  1 = store, 0 = load.
- REQ_ADDR  in  ADDR_WIDTH  byte address.
- REQ_SIZE  in  2  00 byte, 01 half, 10 word, 11 illegal.
- REQ_UNSIGNED  in  1  load zero-extends when 1, sign-extends when 0.
- REQ_WDATA  in  32  store data, LSB-aligned.
- RSP_VALID  out  1  one-cycle response pulse.
- RSP_RDATA  out  32  load result; 0 for stores and errors.
- RSP_ERR  out  1  request rejected; no lane was touched.
- LANE_W_ADDR  out  4*(ADDR_WIDTH-2)  per-lane write row; lane i in slice i.
- LANE_R_ADDR  out  4*(ADDR_WIDTH-2)  per-lane read row.
- LANE_WE  out  4  per-lane write enable.
- LANE_RE  out  4  per-lane read enable.
- LANE_DIN  out  32  lane i byte in bits [8i+7:8i].
- LANE_DOUT  in  32  lane i read byte, valid the cycle after LANE_RE[i].

Behaviour:
- Reset values:
  - State IDLE, REQ_READY=1.
  - RSP_VALID=0, RSP_ERR=0, RSP_RDATA=0.
  - LANE_WE=0, LANE_RE=0, all lane address and data outputs 0.
  - All lane enables are gated by !RST, so reset mid-operation never writes or reads a lane in the reset cycle.
- Handshake:
  - Accept when REQ_VALID & REQ_READY at a posedge.
  - REQ_READY=1 only in IDLE.
  - Addr, size, we, unsigned and wdata are captured into registers.
  - No response backpressure: RSP_VALID is high exactly one cycle.
- Lane mapping (n = 1/2/4 bytes, o = addr[1:0], r = addr[ADDR_WIDTH-1:2]):
  - Request byte k (k < n) uses lane (o+k) mod 4.
  - Its row is r, or r+1 when o+k >= 4.
  - Untouched lanes have WE=RE=0 and address 0.
- Error checks, evaluated at accept; any match is an error:
  - REQ_SIZE==11.
  - r is the top row and o+n > 4.
  - Misalignment rule; see Optional Feature.
- FSM states:
  - IDLE: on accept, go to ACCESS, or to RESP with err=1 if an error check matches.
  - ACCESS (1 cycle): drive lane WE/RE, addresses and DIN from the captured registers. Store goes to RESP; load goes to COLLECT.
  - COLLECT (1 cycle): sample LANE_DOUT. Byte k = lane (o+k) mod 4 data. Bits above 8n are sign-extended from bit 8n-1, or zeroed if unsigned. Register into RSP_RDATA; go to RESP.
  - RESP (1 cycle): RSP_VALID=1 and RSP_ERR=err. Go to IDLE.
- Latency from accept edge T:
  - Error response at T+1.
  - Store: lane write in T+1, response at T+2.
  - Load: response at T+3.
- Registers:
  - RSP_RDATA holds its value until the next load response.
  - It is cleared to 0 on store and error responses.
- Requests arriving while busy are ignored. The requester must hold REQ_VALID until REQ_READY.

Optional Feature:
- Macro DMEM_MISALIGN_EN.
- Defined: misaligned half (o=3) and misaligned word (o!=0) are legal and complete in a single access, with lanes split across rows r and r+1 as described above.
- Undefined: any half with o[0]=1 or word with o!=0 is an error (RSP_ERR=1, RSP_VALID at T+1, no lane enables). The top-row check becomes unreachable except for REQ_SIZE==11.

Test Plan:
- Reset: assert RST during ACCESS of a store to 0x10 -> LANE_WE stays 0 that cycle; after release REQ_READY=1 and lane 0 row 4 is unchanged.
- Store word 0xDEADBEEF to 0x08, then load word 0x08 -> lanes 0..3 row 2 get EF,BE,AD,DE; RSP_RDATA=0xDEADBEEF at T+3; RSP_ERR=0.
- Store byte 0x80 to 0x05; load signed byte -> 0xFFFFFF80; load unsigned byte -> 0x00000080; only LANE_WE[1] pulses on the store.
- Load half at 0x0E after storing 0x1234 -> lanes 2,3 read at row 3; RSP_RDATA=0x00001234.
- REQ_SIZE=11 at 0x00 -> RSP_VALID and RSP_ERR at T+1, RSP_RDATA=0, no lane enables.
- Misaligned word store 0xA1B2C3D4 to 0x0B:
  - With DMEM_MISALIGN_EN: lane3 row2=D4, lanes0..2 row3=C3,B2,A1; a load back returns 0xA1B2C3D4.
  - Same store at 0xFF with ADDR_WIDTH=8 -> RSP_ERR.
  - Without DMEM_MISALIGN_EN: the 0x0B store gives RSP_ERR at T+1 and no writes.
